keypad_debouncer: RTL and testbench
===================================

# keypad_debouncer

Consumes the synchronized row/column samples produced by the keypad scanner. Locks onto a single pressed key and debounces both press and release across whole scan rounds. Emits the key's 4-bit hex code with a one-cycle strobe per debounced press. Sits between the scanner and the display/key-history logic; later keys are locked out until the held key is released.

## Interface
- DEBOUNCE_SCANS, default 20: consecutive scan observations required to accept a press or a release (≥1).
- clk  input  1  system clock; same clock as the scanner.
- reset  input  1  asynchronous, active-low reset.
- rowsSync  input  4  synchronized row sample; a high bit means that row is conducting.
- colsSync  input  4  synchronized column drive, one-hot and rotating, aligned with rowsSync.
- key  output  4  hex code of the last accepted key; holds its value until the next accepted press.
- newKey  output  1  one-cycle strobe, high in the cycle key first shows a newly accepted code.
- keyHeld  output  1  high from acceptance until the debounced release completes.

## Operation
- Observation: a cycle where colsSync is exactly one-hot. Non-one-hot colsSync (e.g. 0000 after reset) is ignored; state and counter hold.
- Column index c comes from colsSync: bit3→0, bit2→1, bit1→2, bit0→3. Row index r comes from rowsSync the same way.
- Key map (r,c), rows 0–3 left to right:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D
- Candidate registers: candCol (one-hot 4), candRow (one-hot 4), cnt (width $clog2(DEBOUNCE_SCANS+1)).
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE: at an observation where rowsSync is exactly one-hot:
  - latch candCol=colsSync and candRow=rowsSync, set cnt=1, go to PRESS_DB.
  - If DEBOUNCE_SCANS=1, go directly to HELD (accept).
  - rowsSync of 0000 or multi-hot: stay in IDLE.
- PRESS_DB: only observations with colsSync==candCol count; all others are ignored.
  - (rowsSync & candRow)≠0: cnt+1. When cnt reaches DEBOUNCE_SCANS, accept.
  - Otherwise (bounce): go to IDLE, cnt=0, no output change.
  - Extra row bits in the candidate column are ignored.
- Accept: key←code(candRow,candCol), newKey=1 for one cycle, keyHeld=1, cnt=0, go to HELD.
- HELD: at candidate-column observations:
  - candidate row low: cnt=1, go to RELEASE_DB (or straight to release complete if DEBOUNCE_SCANS=1).
  - Keys in other columns or rows are ignored (lockout).
- RELEASE_DB: at candidate-column observations:
  - row low: cnt+1. At DEBOUNCE_SCANS, release completes: keyHeld=0, cnt=0, go to IDLE.
  - row high again: cnt=0, return to HELD. No new strobe is issued.
- Release completes before any new press can start; the earliest new candidate is latched at the next IDLE observation.
- Counter never exceeds DEBOUNCE_SCANS and never wraps.

## Timing
- Reset values: state=IDLE, key=4'h0, newKey=0, keyHeld=0, cnt=0, candCol=0, candRow=0.
- All outputs are registered.
- newKey and keyHeld rise in the cycle after the clock edge that samples the accepting observation. key updates on that same edge.
- keyHeld falls on the edge after the final release observation.
- Minimum press latency from the first candidate observation: (DEBOUNCE_SCANS−1)×4+1 cycles, with a 4-cycle scan round.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously), with no strobe. Operation resumes in IDLE on the first edge after deassertion.
- Exactly one newKey pulse per accepted press, regardless of hold length.

## Test plan
- Clean press, DEBOUNCE_SCANS=3: row1 high while col bit2 active for 3 rounds → single newKey pulse, key=4'h5, keyHeld=1; hold 20 rounds → no further pulses.
- Bounce, DEBOUNCE_SCANS=3: candidate seen 2 rounds, absent 1, present 3 → exactly one pulse, occurring only after the final 3 consecutive rounds.
- Release debounce: from HELD, row low 2 rounds then high 1 → keyHeld stays 1, no pulse. Then low 3 rounds → keyHeld=0.
- Lockout: hold key 4'hA (r0, col bit0) and press key 4'h0 (r3, col bit2) → key stays 4'hA. Release 4'hA with 4'h0 still held → after release, a new press of 4'h0 is accepted, key=4'h0.
- Invalid input: rowsSync=4'b0011 in IDLE, colsSync=0000 → no candidate, outputs stay at reset values.
- Async reset: assert reset mid-PRESS_DB and mid-HELD → key=0, newKey=0, keyHeld=0 without waiting for clk; no pulse after deassertion unless a full debounce follows.

Source files
------------

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: locks onto one pressed key from the scanner samples,
// debounces press and release over whole scan rounds, and reports the key's
// hex code with a one-cycle strobe per accepted press.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no key held; waiting for a single-row hit in any column
// PRESS_DB   | candidate latched; counting consecutive hits in its column
// HELD       | key accepted; other keys locked out
// RELEASE_DB | candidate row seen low; counting consecutive misses
module keypad_debouncer #(
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rowsSync,
    input  logic [3:0] colsSync,
    output logic [3:0] key,
    output logic       newKey,
    output logic       keyHeld
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    // With a single required scan, the first hit accepts and the first miss releases.
    localparam bit SINGLE = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       candCol, candCol_nxt;
    logic [3:0]       candRow, candRow_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       key_nxt;
    logic             newKey_nxt;
    logic             keyHeld_nxt;

    logic obs;
    logic cand_obs;
    logic row_hit;

    // Bit 3 is index 0, bit 0 is index 3, for both rows and columns.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [3:0] row, input logic [3:0] col);
        logic [3:0] rc;
        logic [3:0] code;
        rc = {onehot_idx(row), onehot_idx(col)};
        case (rc)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign obs      = $onehot(colsSync);
    assign cand_obs = obs && (colsSync == candCol);
    assign row_hit  = |(rowsSync & candRow);

    // Next-state, candidate, counter and output decisions.
    always_comb begin
        state_nxt   = state;
        candCol_nxt = candCol;
        candRow_nxt = candRow;
        cnt_nxt     = cnt;
        key_nxt     = key;
        newKey_nxt  = 1'b0;
        keyHeld_nxt = keyHeld;
        case (state)
            IDLE: begin
                if (obs && $onehot(rowsSync)) begin
                    candCol_nxt = colsSync;
                    candRow_nxt = rowsSync;
                    if (SINGLE) begin
                        key_nxt     = key_code(rowsSync, colsSync);
                        newKey_nxt  = 1'b1;
                        keyHeld_nxt = 1'b1;
                        cnt_nxt     = CNT_ZERO;
                        state_nxt   = HELD;
                    end else begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = PRESS_DB;
                    end
                end
            end
            PRESS_DB: begin
                if (cand_obs) begin
                    if (row_hit) begin
                        if (cnt == CNT_LAST) begin
                            key_nxt     = key_code(candRow, candCol);
                            newKey_nxt  = 1'b1;
                            keyHeld_nxt = 1'b1;
                            cnt_nxt     = CNT_ZERO;
                            state_nxt   = HELD;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end else begin
                        cnt_nxt   = CNT_ZERO;
                        state_nxt = IDLE;
                    end
                end
            end
            HELD: begin
                if (cand_obs && !row_hit) begin
                    if (SINGLE) begin
                        keyHeld_nxt = 1'b0;
                        cnt_nxt     = CNT_ZERO;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = RELEASE_DB;
                    end
                end
            end
            RELEASE_DB: begin
                if (cand_obs) begin
                    if (!row_hit) begin
                        if (cnt == CNT_LAST) begin
                            keyHeld_nxt = 1'b0;
                            cnt_nxt     = CNT_ZERO;
                            state_nxt   = IDLE;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end else begin
                        cnt_nxt   = CNT_ZERO;
                        state_nxt = HELD;
                    end
                end
            end
            default: begin
                cnt_nxt   = CNT_ZERO;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, candidate, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            candCol <= 4'h0;
            candRow <= 4'h0;
            cnt     <= CNT_ZERO;
            key     <= 4'h0;
            newKey  <= 1'b0;
            keyHeld <= 1'b0;
        end else begin
            state   <= state_nxt;
            candCol <= candCol_nxt;
            candRow <= candRow_nxt;
            cnt     <= cnt_nxt;
            key     <= key_nxt;
            newKey  <= newKey_nxt;
            keyHeld <= keyHeld_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DEBOUNCE_SCANS=3 and a 4-cycle
// scan round (column bit 3, 2, 1, 0).
module tb_keypad_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rowsSync;
    logic [3:0] colsSync;
    logic [3:0] key;
    logic       newKey;
    logic       keyHeld;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Row pattern returned while column bit b is driven.
    logic [3:0] rows_at [4];

    keypad_debouncer #(.DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .rowsSync (rowsSync),
        .colsSync (colsSync),
        .key      (key),
        .newKey   (newKey),
        .keyHeld  (keyHeld)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Counts cycles with the strobe high; a stretched strobe counts more than once.
    always @(negedge clk) if (newKey === 1'b1) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_rounds(input int n);
        for (int r = 0; r < n; r++) begin
            for (int b = 3; b >= 0; b--) begin
                colsSync    = 4'h0;
                colsSync[b] = 1'b1;
                rowsSync    = rows_at[b];
                @(posedge clk);
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic run_raw(input logic [3:0] cols, input logic [3:0] rows, input int n);
        colsSync = cols;
        rowsSync = rows;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b0;
        rowsSync = 4'h0;
        colsSync = 4'h0;
        rows_at  = '{default: 4'h0};
        repeat (3) @(negedge clk);
        #1;
        chk("reset_key", 32'(key), 0);
        chk("reset_newKey", 32'(newKey), 0);
        chk("reset_keyHeld", 32'(keyHeld), 0);
        reset = 1'b1;

        // Invalid input: no column drive, then multi-hot rows.
        run_raw(4'b0000, 4'b0011, 8);
        chk("nocol_key", 32'(key), 0);
        chk("nocol_keyHeld", 32'(keyHeld), 0);
        chk("nocol_pulses", 32'(pulses), 0);
        rows_at = '{default: 4'b0011};
        run_rounds(4);
        chk("multihot_keyHeld", 32'(keyHeld), 0);
        chk("multihot_pulses", 32'(pulses), 0);

        // Clean press of key 5 (row1, column bit2).
        rows_at    = '{default: 4'h0};
        rows_at[2] = 4'b0100;
        run_rounds(2);
        chk("press5_early_pulses", 32'(pulses), 0);
        chk("press5_early_keyHeld", 32'(keyHeld), 0);
        run_rounds(1);
        chk("press5_pulses", 32'(pulses), 1);
        chk("press5_key", 32'(key), 'h5);
        chk("press5_keyHeld", 32'(keyHeld), 1);
        run_rounds(20);
        chk("hold5_pulses", 32'(pulses), 1);
        chk("hold5_keyHeld", 32'(keyHeld), 1);

        // Release debounce with a bounce back to held.
        rows_at[2] = 4'h0;
        run_rounds(2);
        chk("rel_partial_keyHeld", 32'(keyHeld), 1);
        rows_at[2] = 4'b0100;
        run_rounds(1);
        rows_at[2] = 4'h0;
        run_rounds(2);
        chk("rel_bounce_keyHeld", 32'(keyHeld), 1);
        chk("rel_bounce_pulses", 32'(pulses), 1);
        run_rounds(1);
        chk("rel_done_keyHeld", 32'(keyHeld), 0);
        chk("rel_done_key", 32'(key), 'h5);
        chk("rel_done_pulses", 32'(pulses), 1);

        // Press bounce on key 9 (row2, column bit1): 2 present, 1 absent, 3 present.
        rows_at[1] = 4'b0010;
        run_rounds(2);
        rows_at[1] = 4'h0;
        run_rounds(1);
        chk("bounce_gap_pulses", 32'(pulses), 1);
        chk("bounce_gap_keyHeld", 32'(keyHeld), 0);
        rows_at[1] = 4'b0010;
        run_rounds(2);
        chk("bounce_early_pulses", 32'(pulses), 1);
        run_rounds(1);
        chk("bounce_pulses", 32'(pulses), 2);
        chk("bounce_key", 32'(key), 'h9);
        chk("bounce_keyHeld", 32'(keyHeld), 1);
        rows_at[1] = 4'h0;
        run_rounds(3);
        chk("bounce_rel_keyHeld", 32'(keyHeld), 0);

        // Lockout: hold A (row0, column bit0), then press 0 (row3, column bit2).
        rows_at[0] = 4'b1000;
        run_rounds(3);
        chk("pressA_key", 32'(key), 'hA);
        chk("pressA_pulses", 32'(pulses), 3);
        rows_at[2] = 4'b0001;
        run_rounds(5);
        chk("lock_key", 32'(key), 'hA);
        chk("lock_pulses", 32'(pulses), 3);
        chk("lock_keyHeld", 32'(keyHeld), 1);
        rows_at[0] = 4'h0;
        run_rounds(2);
        chk("relA_partial_keyHeld", 32'(keyHeld), 1);
        run_rounds(1);
        chk("relA_keyHeld", 32'(keyHeld), 0);
        chk("relA_key", 32'(key), 'hA);
        run_rounds(2);
        chk("press0_early_pulses", 32'(pulses), 3);
        run_rounds(1);
        chk("press0_key", 32'(key), 'h0);
        chk("press0_pulses", 32'(pulses), 4);
        chk("press0_keyHeld", 32'(keyHeld), 1);
        rows_at = '{default: 4'h0};
        run_rounds(3);
        chk("rel0_keyHeld", 32'(keyHeld), 0);

        // Async reset while HELD on key 5.
        rows_at[2] = 4'b0100;
        run_rounds(3);
        chk("pre_rst_key", 32'(key), 'h5);
        chk("pre_rst_pulses", 32'(pulses), 5);
        reset = 1'b0;
        #2;
        chk("rst_held_key", 32'(key), 0);
        chk("rst_held_newKey", 32'(newKey), 0);
        chk("rst_held_keyHeld", 32'(keyHeld), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        run_rounds(2);
        chk("after_rst_pulses", 32'(pulses), 5);
        chk("after_rst_keyHeld", 32'(keyHeld), 0);

        // Async reset while PRESS_DB; counting must restart from scratch.
        reset = 1'b0;
        #2;
        chk("rst_pdb_keyHeld", 32'(keyHeld), 0);
        chk("rst_pdb_newKey", 32'(newKey), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        run_rounds(2);
        chk("restart_early_pulses", 32'(pulses), 5);
        chk("restart_early_keyHeld", 32'(keyHeld), 0);
        run_rounds(1);
        chk("restart_pulses", 32'(pulses), 6);
        chk("restart_key", 32'(key), 'h5);
        chk("restart_keyHeld", 32'(keyHeld), 1);
        run_rounds(2);
        chk("final_newKey", 32'(newKey), 0);
        chk("final_pulses", 32'(pulses), 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
